uart_tx_device: RTL and testbench

UART_TX_DEVICE -- requirements
Module: uart_tx_device

---
 rtl/uart_pkg.sv | 25 ++
 rtl/sync_fifo.sv | 53 +++++
 rtl/uart_tx_device.sv | 166 ++++++++++++++++
 tb/tb_uart_tx_device.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: register offsets, STATUS/CTRL bit positions and the
// transmit FSM state encoding, also used by the CPU-side software tests.
package uart_pkg;

    localparam logic [31:0] TXDATA_OFS = 32'h0;
    localparam logic [31:0] STATUS_OFS = 32'h4;
    localparam logic [31:0] CTRL_OFS   = 32'h8;

    localparam int unsigned STATUS_BUSY      = 0;
    localparam int unsigned STATUS_FULL      = 1;
    localparam int unsigned STATUS_EMPTY     = 2;
    localparam int unsigned STATUS_OVERFLOW  = 3;
    localparam int unsigned STATUS_COUNT_LSB = 4;

    localparam int unsigned CTRL_TX_EN  = 0;
    localparam int unsigned CTRL_IRQ_EN = 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } tx_state_t;

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with power-of-two depth; a push while full is accepted only
// when a pop happens on the same edge.
module sync_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign full    = (count == CW'(DEPTH));
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/uart_tx_device.sv
// Memory-mapped UART transmitter: bus register decode, TX FIFO, baud-timed
// 8N1 framing FSM and a level interrupt when the transmitter drains.
module uart_tx_device
    import uart_pkg::*;
#(
    parameter int unsigned BAUD_DIV   = 868,
    parameter int unsigned FIFO_DEPTH = 4,
    parameter logic [31:0] BASE_ADDR  = 32'h4000_0010
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        MemRead,
    input  logic        MemWrite,
    input  logic [31:0] MemBus_Address,
    input  logic [31:0] MemBus_Write_Data,
    output logic [31:0] Device_Read_Data,
    output logic        uart_tx,
    output logic        irq
);

    localparam int unsigned CW          = $clog2(FIFO_DEPTH) + 1;
    localparam logic [15:0] BAUD_LAST   = 16'(BAUD_DIV - 1);
    localparam logic [31:0] TXDATA_ADDR = BASE_ADDR + TXDATA_OFS;
    localparam logic [31:0] STATUS_ADDR = BASE_ADDR + STATUS_OFS;
    localparam logic [31:0] CTRL_ADDR   = BASE_ADDR + CTRL_OFS;

    tx_state_t     state;
    logic [15:0]   baud_cnt;
    logic [7:0]    shift;
    logic [2:0]    bit_idx;
    logic          tx_en;
    logic          irq_en;
    logic          overflow;
    logic          busy;
    logic          sel_txdata, sel_status, sel_ctrl;
    logic          push, pop, start_frame;
    logic [7:0]    fifo_dout;
    logic          fifo_full, fifo_empty;
    logic [CW-1:0] fifo_count;
    logic          bus_unused;

    assign bus_unused = ^{MemBus_Address[1:0], MemBus_Write_Data[31:8]};

    assign sel_txdata = (MemBus_Address[31:2] == TXDATA_ADDR[31:2]);
    assign sel_status = (MemBus_Address[31:2] == STATUS_ADDR[31:2]);
    assign sel_ctrl   = (MemBus_Address[31:2] == CTRL_ADDR[31:2]);

    assign busy = (state != ST_IDLE);
    assign push = MemWrite & sel_txdata;
    // A frame may start from IDLE or directly from the last STOP cycle, so
    // back-to-back bytes leave no idle gap on the line.
    assign start_frame = tx_en & ~fifo_empty &
                         ((state == ST_IDLE) || (state == ST_STOP && baud_cnt == '0));
    assign pop = start_frame;

    sync_fifo #(
        .WIDTH(8),
        .DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .pop   (pop),
        .din   (MemBus_Write_Data[7:0]),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tx_en    <= 1'b0;
            irq_en   <= 1'b0;
            overflow <= 1'b0;
            irq      <= 1'b0;
        end else begin
            if (MemWrite && sel_ctrl) begin
                tx_en  <= MemBus_Write_Data[CTRL_TX_EN];
                irq_en <= MemBus_Write_Data[CTRL_IRQ_EN];
            end
            if (push && fifo_full && !pop)
                overflow <= 1'b1;
            else if (MemWrite && sel_status && MemBus_Write_Data[STATUS_OVERFLOW])
                overflow <= 1'b0;
            irq <= irq_en & fifo_empty & ~busy;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= ST_IDLE;
            baud_cnt <= '0;
            shift    <= '0;
            bit_idx  <= '0;
            uart_tx  <= 1'b1;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start_frame) begin
                        state    <= ST_START;
                        shift    <= fifo_dout;
                        baud_cnt <= BAUD_LAST;
                        uart_tx  <= 1'b0;
                    end
                end
                ST_START: begin
                    if (baud_cnt == '0) begin
                        state    <= ST_DATA;
                        bit_idx  <= '0;
                        baud_cnt <= BAUD_LAST;
                        uart_tx  <= shift[0];
                    end else begin
                        baud_cnt <= baud_cnt - 1'b1;
                    end
                end
                ST_DATA: begin
                    if (baud_cnt == '0) begin
                        baud_cnt <= BAUD_LAST;
                        bit_idx  <= bit_idx + 1'b1;
                        if (bit_idx == 3'd7) begin
                            state   <= ST_STOP;
                            uart_tx <= 1'b1;
                        end else begin
                            uart_tx <= shift[bit_idx + 3'd1];
                        end
                    end else begin
                        baud_cnt <= baud_cnt - 1'b1;
                    end
                end
                ST_STOP: begin
                    if (baud_cnt == '0) begin
                        if (start_frame) begin
                            state    <= ST_START;
                            shift    <= fifo_dout;
                            baud_cnt <= BAUD_LAST;
                            uart_tx  <= 1'b0;
                        end else begin
                            state <= ST_IDLE;
                        end
                    end else begin
                        baud_cnt <= baud_cnt - 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    always_comb begin
        Device_Read_Data = '0;
        if (MemRead) begin
            if (sel_status) begin
                Device_Read_Data[STATUS_BUSY]                = busy;
                Device_Read_Data[STATUS_FULL]                = fifo_full;
                Device_Read_Data[STATUS_EMPTY]               = fifo_empty;
                Device_Read_Data[STATUS_OVERFLOW]            = overflow;
                Device_Read_Data[STATUS_COUNT_LSB +: CW]     = fifo_count;
            end else if (sel_ctrl) begin
                Device_Read_Data[CTRL_TX_EN]  = tx_en;
                Device_Read_Data[CTRL_IRQ_EN] = irq_en;
            end
        end
    end

endmodule

// File: tb/tb_uart_tx_device.sv
// Directed bench for uart_tx_device with BAUD_DIV=4 and a 4-entry FIFO;
// expected line waveforms, register values and timings are hand-computed.
module tb_uart_tx_device;

    localparam logic [31:0] BASE   = 32'h4000_0010;
    localparam logic [31:0] TXDATA = BASE;
    localparam logic [31:0] STATUS = BASE + 32'd4;
    localparam logic [31:0] CTRL   = BASE + 32'd8;
    localparam logic [31:0] UNMAP  = BASE + 32'd12;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        MemRead = 1'b0;
    logic        MemWrite = 1'b0;
    logic [31:0] MemBus_Address = '0;
    logic [31:0] MemBus_Write_Data = '0;
    logic [31:0] Device_Read_Data;
    logic        uart_tx;
    logic        irq;

    int unsigned vectors = 0;
    int unsigned miscompares = 0;

    uart_tx_device #(
        .BAUD_DIV(4),
        .FIFO_DEPTH(4),
        .BASE_ADDR(32'h4000_0010)
    ) dut (
        .clk               (clk),
        .reset             (reset),
        .MemRead           (MemRead),
        .MemWrite          (MemWrite),
        .MemBus_Address    (MemBus_Address),
        .MemBus_Write_Data (MemBus_Write_Data),
        .Device_Read_Data  (Device_Read_Data),
        .uart_tx           (uart_tx),
        .irq               (irq)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got 'h%0h, expected 'h%0h", tag, got, exp);
        end
    endtask

    task automatic bus_write(input logic [31:0] addr, input logic [31:0] data);
        @(negedge clk);
        MemWrite = 1'b1;
        MemBus_Address = addr;
        MemBus_Write_Data = data;
        @(posedge clk);
        #1;
        MemWrite = 1'b0;
        MemBus_Address = '0;
        MemBus_Write_Data = '0;
    endtask

    task automatic bus_read(input logic [31:0] addr, output logic [31:0] data);
        MemRead = 1'b1;
        MemBus_Address = addr;
        #1;
        data = Device_Read_Data;
        MemRead = 1'b0;
        MemBus_Address = '0;
    endtask

    initial begin
        logic [31:0] rd;
        logic [39:0] wave;
        logic [9:0]  frame;
        logic [7:0]  rx_bytes [5];
        logic        frame_ok;
        int unsigned busy_cycles;
        int unsigned first_irq;
        int unsigned low_cycles;

        // Reset state, sampled while reset is still asserted
        repeat (2) @(posedge clk);
        #1;
        check("reset_uart_tx", 64'(uart_tx), 64'd1);
        check("reset_irq", 64'(irq), 64'd0);
        bus_read(STATUS, rd);
        check("reset_status", 64'(rd), 64'h4);
        bus_read(CTRL, rd);
        check("reset_ctrl", 64'(rd), 64'h0);
        @(negedge clk);
        reset = 1'b0;

        // Single A5 frame: 4-cycle bits, busy for exactly 40 cycles
        bus_write(CTRL, 32'h1);
        bus_write(TXDATA, 32'hA5);
        wave = '0;
        busy_cycles = 0;
        for (int i = 0; i < 48; i++) begin
            @(posedge clk);
            #1;
            if (i < 40) wave[i] = uart_tx;
            bus_read(STATUS, rd);
            if (rd[0]) busy_cycles++;
        end
        check("a5_waveform", 64'(wave), 64'hFF_0F00_F0F0);
        check("a5_busy_cycles", 64'(busy_cycles), 64'd40);
        check("a5_idle_line", 64'(uart_tx), 64'd1);

        // irq rises one cycle after STOP ends, falls one cycle after irq_en clears
        bus_write(CTRL, 32'h0);
        bus_write(TXDATA, 32'h5A);
        bus_write(CTRL, 32'h3);
        first_irq = 99;
        for (int i = 0; i < 60; i++) begin
            if (i > 0) begin
                @(posedge clk);
                #1;
            end else begin
                @(posedge clk);
                #1;
            end
            if (irq && first_irq == 99) first_irq = i;
        end
        check("irq_rise_cycle", 64'(first_irq), 64'd41);
        bus_write(CTRL, 32'h1);
        check("irq_after_ctrl_edge", 64'(irq), 64'd1);
        @(posedge clk);
        #1;
        check("irq_cleared", 64'(irq), 64'd0);

        // Overflow with tx disabled, TXDATA reads zero, sticky clear by STATUS write
        bus_write(CTRL, 32'h0);
        for (int b = 1; b <= 5; b++) bus_write(TXDATA, 32'(b));
        bus_read(STATUS, rd);
        check("overflow_status", 64'(rd), 64'h4A);
        bus_read(TXDATA, rd);
        check("txdata_reads_zero", 64'(rd), 64'h0);
        bus_write(STATUS, 32'h8);
        bus_read(STATUS, rd);
        check("overflow_cleared", 64'(rd), 64'h42);

        // Push and pop on the same edge with FIFO full: no overflow, order kept
        bus_write(CTRL, 32'h1);
        bus_write(TXDATA, 32'h05);
        bus_read(STATUS, rd);
        check("full_push_pop_status", 64'(rd), 64'h43);
        frame_ok = 1'b1;
        for (int k = 0; k < 5; k++) rx_bytes[k] = '0;
        for (int i = 0; i < 200; i++) begin
            if (i > 0) begin
                @(posedge clk);
                #1;
            end
            if (i % 4 == 2) begin
                frame[(i % 40) / 4] = uart_tx;
                if ((i % 40) / 4 == 9) begin
                    if (frame[0] !== 1'b0 || frame[9] !== 1'b1) frame_ok = 1'b0;
                    rx_bytes[i / 40] = frame[8:1];
                end
            end
        end
        for (int k = 0; k < 5; k++) check($sformatf("rx_byte%0d", k), 64'(rx_bytes[k]), 64'(k + 1));
        check("rx_framing", 64'(frame_ok), 64'd1);
        @(posedge clk);
        #1;
        bus_read(STATUS, rd);
        check("drained_status", 64'(rd), 64'h4);

        // Asynchronous reset in the middle of the second frame's data bits
        bus_write(CTRL, 32'h0);
        bus_write(TXDATA, 32'h3C);
        bus_write(TXDATA, 32'h00);
        bus_write(CTRL, 32'h1);
        repeat (57) @(posedge clk);
        #3;
        check("second_frame_data_low", 64'(uart_tx), 64'd0);
        reset = 1'b1;
        #1;
        check("reset_mid_frame_line", 64'(uart_tx), 64'd1);
        bus_read(STATUS, rd);
        check("reset_mid_frame_status", 64'(rd), 64'h4);
        @(negedge clk);
        reset = 1'b0;
        low_cycles = 0;
        busy_cycles = 0;
        for (int i = 0; i < 60; i++) begin
            @(posedge clk);
            #1;
            if (!uart_tx) low_cycles++;
            bus_read(STATUS, rd);
            if (rd[0]) busy_cycles++;
        end
        check("no_frame_after_reset", 64'(low_cycles), 64'd0);
        check("no_busy_after_reset", 64'(busy_cycles), 64'd0);

        // Unmapped address and MemRead=0 return zero; unmapped write is ignored
        bus_write(CTRL, 32'h2);
        bus_read(UNMAP, rd);
        check("unmapped_read", 64'(rd), 64'h0);
        MemBus_Address = STATUS;
        #1;
        check("read_strobe_low", 64'(Device_Read_Data), 64'h0);
        MemBus_Address = '0;
        bus_write(UNMAP, 32'hFFFF_FFFF);
        bus_read(CTRL, rd);
        check("unmapped_write_ctrl", 64'(rd), 64'h2);
        bus_read(STATUS, rd);
        check("unmapped_write_status", 64'(rd), 64'h4);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
